// File: rtl/ifft_pkg.sv
// Shared types and constants for the 8-point streaming inverse FFT.
package ifft_pkg;
    localparam int N    = 8;
    localparam int W    = 16;
    localparam int FRAC = 12;

    localparam logic signed [W-1:0] TW_P707 = 16'sh0B50;
    localparam logic signed [W-1:0] TW_N707 = 16'shF4B0;
    localparam logic signed [31:0]  ROUND   = 32'sh800;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_UNLOAD
    } state_t;

    // Multiply by +j: (re, im) -> (-im, re), negation wraps at W bits.
    function automatic cplx_t mul_j(cplx_t b);
        cplx_t r;
        r.re = -$signed(b.im);
        r.im = $signed(b.re);
        return r;
    endfunction
endpackage

// File: rtl/ifft_bfly_scaled.sv
// Combinational radix-2 butterfly p = a+b, m = a-b at W+1 bits.
// IFFT_STAGE_SCALE_EN halves each output with round-half-up; otherwise outputs wrap to W bits.
module ifft_bfly_scaled
    import ifft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    output cplx_t p,
    output cplx_t m
);
    logic signed [W:0] sr, si, dr, di;

    assign sr = $signed(a.re) + $signed(b.re);
    assign si = $signed(a.im) + $signed(b.im);
    assign dr = $signed(a.re) - $signed(b.re);
    assign di = $signed(a.im) - $signed(b.im);

`ifdef IFFT_STAGE_SCALE_EN
    assign p.re = W'((sr + 17'sd1) >>> 1);
    assign p.im = W'((si + 17'sd1) >>> 1);
    assign m.re = W'((dr + 17'sd1) >>> 1);
    assign m.im = W'((di + 17'sd1) >>> 1);
`else
    assign p.re = W'(sr);
    assign p.im = W'(si);
    assign m.re = W'(dr);
    assign m.im = W'(di);
`endif
endmodule

// File: rtl/ifft_8_stream.sv
// Serial-in / serial-out 8-point radix-2 DIT inverse FFT, Q4.12 complex samples.
// Optional per-stage 1/2 scaling via IFFT_STAGE_SCALE_EN (see ifft_bfly_scaled).
//
// state  | meaning
// LOAD   | accept 8 bins X[0..7] into the input buffer, in_ready=1
// S1     | register stage-1 butterflies on bit-reversed pairs
// S2     | register stage-2 butterflies (+j twiddle on odd pairs)
// S3     | register stage-3 butterflies into the output buffer
// UNLOAD | stream x[0..7] with out_valid, out_last on x[7]
module ifft_8_stream
    import ifft_pkg::*;
#(
    parameter int W    = ifft_pkg::W,
    parameter int FRAC = ifft_pkg::FRAC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last
);
    state_t     state;
    logic [2:0] in_cnt;
    logic [2:0] out_cnt;

    cplx_t bufr [N];
    cplx_t s1   [N];
    cplx_t s2   [N];
    cplx_t obuf [N];

    cplx_t s1n  [N];
    cplx_t s2n  [N];
    cplx_t s3n  [N];
    cplx_t tw2  [4];
    cplx_t tw3  [4];

    // Products summed at 32 bits, rounded, then Q4.12 re-aligned with wrap.
    function automatic cplx_t cmul(cplx_t b, logic signed [W-1:0] wr, logic signed [W-1:0] wi);
        logic signed [2*W-1:0] pr;
        logic signed [2*W-1:0] pi;
        cplx_t r;
        pr   = $signed(b.re) * wr - $signed(b.im) * wi + ROUND;
        pi   = $signed(b.re) * wi + $signed(b.im) * wr + ROUND;
        r.re = W'(pr >>> FRAC);
        r.im = W'(pi >>> FRAC);
        return r;
    endfunction

    genvar i;
    for (i = 0; i < 4; i++) begin : g_st1
        localparam int A = ((i % 2) * 2) + (i / 2);
        ifft_bfly_scaled u_bf (
            .a(bufr[A]), .b(bufr[A+4]), .p(s1n[2*i]), .m(s1n[2*i+1])
        );
    end

    for (i = 0; i < 4; i++) begin : g_st2
        localparam int G = i / 2;
        localparam int J = i % 2;
        if (J == 0) begin : g_w0
            assign tw2[i] = s1[4*G+J+2];
        end else begin : g_wj
            assign tw2[i] = mul_j(s1[4*G+J+2]);
        end
        ifft_bfly_scaled u_bf (
            .a(s1[4*G+J]), .b(tw2[i]), .p(s2n[4*G+J]), .m(s2n[4*G+J+2])
        );
    end

    for (i = 0; i < 4; i++) begin : g_st3
        if (i == 0) begin : g_w0
            assign tw3[i] = s2[4];
        end else if (i == 1) begin : g_w1
            assign tw3[i] = cmul(s2[5], TW_P707, TW_P707);
        end else if (i == 2) begin : g_w2
            assign tw3[i] = mul_j(s2[6]);
        end else begin : g_w3
            assign tw3[i] = cmul(s2[7], TW_N707, TW_P707);
        end
        ifft_bfly_scaled u_bf (
            .a(s2[i]), .b(tw3[i]), .p(s3n[i]), .m(s3n[i+4])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            for (int k = 0; k < N; k++) begin
                bufr[k] <= '0;
                s1[k]   <= '0;
                s2[k]   <= '0;
                obuf[k] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        bufr[in_cnt].re <= in_re;
                        bufr[in_cnt].im <= in_im;
                        if (in_cnt == 3'd7) begin
                            in_cnt   <= '0;
                            in_ready <= 1'b0;
                            state    <= ST_S1;
                        end else begin
                            in_cnt <= in_cnt + 3'd1;
                        end
                    end
                end
                ST_S1: begin
                    for (int k = 0; k < N; k++) s1[k] <= s1n[k];
                    state <= ST_S2;
                end
                ST_S2: begin
                    for (int k = 0; k < N; k++) s2[k] <= s2n[k];
                    state <= ST_S3;
                end
                ST_S3: begin
                    for (int k = 0; k < N; k++) obuf[k] <= s3n[k];
                    // obuf is written this edge, so present x[0] straight from the stage output.
                    out_re    <= s3n[0].re;
                    out_im    <= s3n[0].im;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_cnt   <= '0;
                    state     <= ST_UNLOAD;
                end
                ST_UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (out_cnt == 3'd7) begin
                            out_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            out_cnt  <= out_cnt + 3'd1;
                            out_re   <= obuf[out_cnt + 3'd1].re;
                            out_im   <= obuf[out_cnt + 3'd1].im;
                            out_last <= (out_cnt == 3'd6);
                        end
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    in_cnt    <= '0;
                    out_cnt   <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule
